kp_ctrl: RTL and testbench
==========================

KP_CTRL -- requirements
Module: kp_ctrl

Interface
REQ-001 SHALL have parameter LATCH_CYC, default 8: KP_LATCH high time in CLK cycles; legal range 2..255.
REQ-002 SHALL have parameter HALF_CYC, default 8: KP_CLK half-period in CLK cycles; legal range 4..255.
REQ-003 SHALL have port CLK, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port RESn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port REQ, input, 2 bits: one-cycle read request per K-Port, active high.
REQ-006 SHALL have port BUSY, output, 1 bit: shift engine owned by a port.
REQ-007 SHALL have port DONE, output, 2 bits: one-cycle completion pulse per port.
REQ-008 SHALL have port DATA0, output, 32 bits: last completed port-0 word, active-high.
REQ-009 SHALL have port DATA1, output, 32 bits: last completed port-1 word, active-high.
REQ-010 SHALL have port KP_LATCH, output, 2 bits: per-port latch strobe.
REQ-011 SHALL have port KP_CLK, output, 2 bits: per-port serial clock.
REQ-012 SHALL have port KP_RW, output, 2 bits: per-port direction; 1 during an active read transfer, else 0.
REQ-013 SHALL have port KP_DIN, input, 2 bits: per-port serial data from device, active-low.
REQ-014 SHALL have port KP_DOUT, output, 2 bits: per-port write data; held 0.

Function
REQ-015 SHALL keep a 2-bit pending register; REQ[i]=1 on a CLK edge sets pending[i], including while port i is being served.
REQ-016 SHALL use states IDLE, LATCH, CLK_LO, CLK_HI, FINISH, with a single shift engine shared by both ports.
REQ-017 In IDLE with any pending bit set, SHALL grant one port, clear its pending bit, and enter LATCH on the same edge.
REQ-018 When both ports are pending, SHALL grant the port not granted last; the last-grant register resets to 1, so port 0 wins first.
REQ-019 In LATCH, KP_LATCH[g]=1 and KP_RW[g]=1 for exactly LATCH_CYC cycles, then the block enters CLK_LO with bit index 0.
REQ-020 In CLK_LO, KP_CLK[g]=0 for HALF_CYC cycles; on the last cycle it SHALL capture ~KP_DIN[g] into shift bit [index], then enter CLK_HI.
REQ-021 In CLK_HI, KP_CLK[g]=1 for HALF_CYC cycles; then index 31 goes to FINISH, otherwise index increments and the block returns to CLK_LO.
REQ-022 Bit 0 is the first bit captured (LSB-first); ports not granted SHALL hold KP_LATCH, KP_CLK and KP_RW at 0 at all times.
REQ-023 In FINISH (1 cycle), SHALL copy the full 32-bit shift word to DATA0 or DATA1 atomically, pulse DONE[g] on the cycle after FINISH, and return to IDLE.
REQ-024 The other port's DATA register SHALL never change during a transfer; partial words are never visible.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 Transfer length from LATCH entry to IDLE SHALL be LATCH_CYC + 64*HALF_CYC + 1 cycles.
REQ-027 Latency: REQ sampled at edge t gives pending at t, grant at t+1, and KP_LATCH high after edge t+1.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On RESn=0, SHALL immediately clear the following (also mid-transfer): pending, state to IDLE, index, shift word, DATA0, DATA1, DONE, BUSY, KP_LATCH, KP_CLK, KP_RW, KP_DOUT, and set last-grant to 1.
REQ-030 On RESn release, SHALL not start a transfer until a new REQ arrives.

Verification
REQ-031 Single read: device model presents 0xF00000A5 on port 0; REQ=01 gives DATA0=0xF00000A5, DONE=01 once, and DATA1 unchanged at 0.
REQ-032 Timing (LATCH_CYC=8, HALF_CYC=8): KP_LATCH[0] high exactly 8 cycles, 32 KP_CLK[0] pulses each 8 high / 8 low, BUSY high 521 cycles.
REQ-033 Simultaneous request: REQ=11 from reset serves port 0 then port 1 back-to-back with no gap beyond the IDLE cycle; DONE order is 01 then 10.
REQ-034 Fairness: port 0 requests continuously while port 1 requests once; port 1 is served right after the current port-0 transfer.
REQ-035 Reset mid-op: RESn pulled low at bit 17 gives all outputs 0 the same cycle, no DONE pulse, and DATA0=0.
REQ-036 Re-request: REQ[1] issued during a port-1 transfer gives exactly two port-1 transfers and two DONE[1] pulses.

Source files
------------

// File: rtl/kp_ctrl.sv
// kp_ctrl: arbitrated serial reader for two K-Ports sharing one shift engine.
// Each port's REQ pulse queues a read. The engine strobes KP_LATCH, then clocks
// 32 bits LSB-first from active-low KP_DIN. The word is published atomically
// to DATA0/DATA1 together with a one-cycle DONE pulse.
// Ports:
//   CLK, RESn         clock, asynchronous active-low reset
//   REQ[1:0]          one-cycle read request per port
//   BUSY              engine owned by a port (any state but IDLE)
//   DONE[1:0]         completion pulse per port
//   DATA0, DATA1      last completed word per port
//   KP_LATCH/CLK/RW   per-port device strobes (only the granted port toggles)
//   KP_DIN[1:0]       per-port serial data from the device, active-low
//   KP_DOUT[1:0]      per-port write data, held 0
module kp_ctrl #(
   parameter int unsigned LATCH_CYC = 8,
   parameter int unsigned HALF_CYC  = 8
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic [1:0]  REQ,
   output logic        BUSY,
   output logic [1:0]  DONE,
   output logic [31:0] DATA0,
   output logic [31:0] DATA1,
   output logic [1:0]  KP_LATCH,
   output logic [1:0]  KP_CLK,
   output logic [1:0]  KP_RW,
   input  logic [1:0]  KP_DIN,
   output logic [1:0]  KP_DOUT
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned WORD_W = 32;

   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WORD_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      CLK_LO = 3'd2,
      CLK_HI = 3'd3,
      FINISH = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        pend_q, pend_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] data0_q, data0_d;
   logic [WORD_W-1:0] data1_q, data1_d;
   logic [1:0]        done_q, done_d;
   logic              busy_q, busy_d;
   logic [1:0]        latch_q, latch_d;
   logic [1:0]        kclk_q, kclk_d;
   logic [1:0]        rw_q, rw_d;
   logic [1:0]        dout_q, dout_d;

   // One-hot port mask for a port number.
   function automatic logic [1:0] port_sel(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   // State and output registers.
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_q <= IDLE;
         pend_q  <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data0_q <= '0;
         data1_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         latch_q <= '0;
         kclk_q  <= '0;
         rw_q    <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         latch_q <= latch_d;
         kclk_q  <= kclk_d;
         rw_q    <= rw_d;
         dout_q  <= dout_d;
      end
   end

   // Arbitration, shift sequencing and next-value of every registered output.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q | REQ;
      last_d  = last_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data0_d = data0_q;
      data1_d = data1_q;
      done_d  = '0;
      dout_d  = '0;

      case (state_q)
         IDLE: begin
            if (pend_q != 2'b00) begin
               // Alternate when both wait; otherwise take the single requester.
               gnt_d   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
               last_d  = gnt_d;
               // A REQ arriving on the grant edge re-queues the same port.
               pend_d  = (pend_q & ~port_sel(gnt_d)) | REQ;
               cnt_d   = '0;
               state_d = LATCH;
            end
         end
         LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = CLK_LO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CLK_LO: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = ~KP_DIN[gnt_q];
               state_d        = CLK_HI;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CLK_HI: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = CLK_LO;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FINISH: begin
            if (gnt_q) data1_d = shift_q;
            else       data0_d = shift_q;
            done_d  = port_sel(gnt_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Strobes follow the next state so they change on the same edge.
      busy_d  = (state_d != IDLE);
      latch_d = (state_d == LATCH)  ? port_sel(gnt_d) : 2'b00;
      kclk_d  = (state_d == CLK_HI) ? port_sel(gnt_d) : 2'b00;
      rw_d    = (state_d != IDLE)   ? port_sel(gnt_d) : 2'b00;
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign DATA0    = data0_q;
   assign DATA1    = data1_q;
   assign KP_LATCH = latch_q;
   assign KP_CLK   = kclk_q;
   assign KP_RW    = rw_q;
   assign KP_DOUT  = dout_q;

endmodule

// File: tb/tb_kp_ctrl.sv
// Bench for kp_ctrl: directed requests with a device model per port, a
// scoreboard queue of expected completions and a DONE-driven monitor.
module tb_kp_ctrl;

   localparam int unsigned LATCH_CYC = 8;
   localparam int unsigned HALF_CYC  = 8;
   localparam int unsigned XFER_CYC  = LATCH_CYC + 64 * HALF_CYC + 1;

   logic        CLK = 1'b0;
   logic        RESn;
   logic [1:0]  REQ;
   logic        BUSY;
   logic [1:0]  DONE;
   logic [31:0] DATA0, DATA1;
   logic [1:0]  KP_LATCH, KP_CLK, KP_RW, KP_DIN, KP_DOUT;

   always #5 CLK = ~CLK;

   kp_ctrl #(.LATCH_CYC(LATCH_CYC), .HALF_CYC(HALF_CYC)) dut (
      .CLK(CLK), .RESn(RESn), .REQ(REQ), .BUSY(BUSY), .DONE(DONE),
      .DATA0(DATA0), .DATA1(DATA1), .KP_LATCH(KP_LATCH), .KP_CLK(KP_CLK),
      .KP_RW(KP_RW), .KP_DIN(KP_DIN), .KP_DOUT(KP_DOUT)
   );

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Device model: bit number = KP_CLK rising edges since the latch strobe.
   logic [31:0] dev_w0, dev_w1;
   logic [5:0]  bc0, bc1;
   logic [1:0]  clk_prev;
   always @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         bc0 <= '0; bc1 <= '0; clk_prev <= '0;
      end else begin
         clk_prev <= KP_CLK;
         if (KP_LATCH[0]) bc0 <= '0;
         else if (KP_CLK[0] && !clk_prev[0]) bc0 <= bc0 + 6'd1;
         if (KP_LATCH[1]) bc1 <= '0;
         else if (KP_CLK[1] && !clk_prev[1]) bc1 <= bc1 + 6'd1;
      end
   end
   assign KP_DIN = ~{dev_w1[bc1[4:0]], dev_w0[bc0[4:0]]};

   // Scoreboard.
   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endfunction

   // Monitor: every DONE pulse pops one expected completion.
   logic [31:0] m0, m1;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;
   always @(negedge CLK) begin
      exp_t e;
      if (!RESn) begin
         m0 = '0; m1 = '0;
      end else if (DONE != 2'b00) begin
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(DONE), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_port", 64'(DONE), e.port ? 64'd2 : 64'd1);
            if (e.port) m1 = e.data;
            else        m0 = e.data;
            chk("data0", 64'(DATA0), 64'(m0));
            chk("data1", 64'(DATA1), 64'(m1));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  64'(BUSY),     64'd0);
      chk({tag, "_done"},  64'(DONE),     64'd0);
      chk({tag, "_data0"}, 64'(DATA0),    64'd0);
      chk({tag, "_data1"}, 64'(DATA1),    64'd0);
      chk({tag, "_latch"}, 64'(KP_LATCH), 64'd0);
      chk({tag, "_kclk"},  64'(KP_CLK),   64'd0);
      chk({tag, "_rw"},    64'(KP_RW),    64'd0);
      chk({tag, "_dout"},  64'(KP_DOUT),  64'd0);
   endtask

   task automatic do_reset();
      @(posedge CLK); #2 RESn = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RESn = 1'b1;
   endtask

   task automatic pulse_req(input logic [1:0] r);
      @(posedge CLK); #1 REQ = r;
      @(posedge CLK); #1 REQ = 2'b00;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || BUSY) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0 || BUSY) chk({name, "_timeout"}, 64'd1, 64'd0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int latch_cnt, rises, busy_cnt, rw_cnt, other_cnt;
      int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, n;
      logic pclk, seen;

      RESn = 1'b0; REQ = 2'b00;
      dev_w0 = 32'hF00000A5; dev_w1 = 32'h12345678;
      #2;
      check_all_zero("reset");
      repeat (3) @(posedge CLK);
      #1 RESn = 1'b1;
      repeat (5) @(negedge CLK);
      chk("no_start_after_reset", 64'(BUSY), 64'd0);

      // Single port-0 read with timing measurement.
      exp_q.push_back('{port: 1'b0, data: 32'hF00000A5});
      @(posedge CLK); #1 REQ = 2'b01;
      @(posedge CLK); #1 REQ = 2'b00;
      chk("latch_before_grant", 64'(KP_LATCH), 64'd0);
      @(posedge CLK); #1;
      chk("latch_after_grant", 64'(KP_LATCH), 64'd1);
      latch_cnt = 0; rises = 0; busy_cnt = 0; rw_cnt = 0; other_cnt = 0;
      hi_run = 0; lo_run = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
      pclk = 1'b0; seen = 1'b0; n = 0;
      while (n < 2000) begin
         @(negedge CLK);
         n++;
         busy_cnt  += int'(BUSY);
         latch_cnt += int'(KP_LATCH[0]);
         rw_cnt    += int'(KP_RW[0]);
         other_cnt += int'(KP_LATCH[1] | KP_CLK[1] | KP_RW[1]);
         if (KP_CLK[0] && !pclk) begin
            rises++;
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
            lo_run = 0;
         end
         if (!KP_CLK[0] && pclk) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
         end
         if (KP_CLK[0]) hi_run++;
         else if (BUSY && !KP_LATCH[0]) lo_run++;
         pclk = KP_CLK[0];
         if (BUSY) seen = 1'b1;
         else if (seen) break;
      end
      chk("latch_cycles", 64'(latch_cnt), 64'(LATCH_CYC));
      chk("kclk_pulses",  64'(rises),     64'd32);
      chk("kclk_hi_min",  64'(hi_min),    64'(HALF_CYC));
      chk("kclk_hi_max",  64'(hi_max),    64'(HALF_CYC));
      chk("kclk_lo_min",  64'(lo_min),    64'(HALF_CYC));
      chk("kclk_lo_max",  64'(lo_max),    64'(HALF_CYC));
      chk("busy_cycles",  64'(busy_cnt),  64'(XFER_CYC));
      chk("rw_cycles",    64'(rw_cnt),    64'(XFER_CYC));
      chk("port1_quiet",  64'(other_cnt), 64'd0);
      wait_drain("single", 1500);
      chk("single_data0", 64'(DATA0), 64'hF00000A5);
      chk("single_data1", 64'(DATA1), 64'd0);

      // Simultaneous request from reset: port 0 first, then port 1.
      do_reset();
      dev_w0 = 32'h80000001; dev_w1 = 32'h5A5AC3C3;
      exp_q.push_back('{port: 1'b0, data: 32'h80000001});
      exp_q.push_back('{port: 1'b1, data: 32'h5A5AC3C3});
      pulse_req(2'b11);
      wait_drain("simul", 2500);
      chk("b2b_gap", 64'(last_done_cyc - prev_done_cyc), 64'(XFER_CYC + 1));

      // Fairness: port 0 held, port 1 pulsed once during port 0 transfer.
      dev_w0 = 32'h0F0F1234; dev_w1 = 32'hDEADBEEF;
      exp_q.push_back('{port: 1'b0, data: 32'h0F0F1234});
      exp_q.push_back('{port: 1'b1, data: 32'hDEADBEEF});
      exp_q.push_back('{port: 1'b0, data: 32'h0F0F1234});
      @(posedge CLK); #1 REQ = 2'b01;
      repeat (50) @(posedge CLK);
      #1 REQ = 2'b11;
      @(posedge CLK); #1 REQ = 2'b01;
      repeat (650) @(posedge CLK);
      #1 REQ = 2'b00;
      wait_drain("fair", 2500);

      // Reset in the middle of a port-0 transfer.
      dev_w0 = 32'hCAFE0001;
      pulse_req(2'b01);
      n = 0;
      while (bc0 != 6'd17 && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("reached_bit17", 64'(bc0), 64'd17);
      @(posedge CLK); #3 RESn = 1'b0;
      #1;
      check_all_zero("midop_reset");
      repeat (3) @(posedge CLK);
      #1 RESn = 1'b1;
      repeat (20) @(negedge CLK);
      chk("midop_no_restart", 64'(BUSY),  64'd0);
      chk("midop_data0",      64'(DATA0), 64'd0);

      // Re-request of port 1 during its own transfer.
      dev_w1 = 32'h7E570001;
      exp_q.push_back('{port: 1'b1, data: 32'h7E570001});
      exp_q.push_back('{port: 1'b1, data: 32'h7E570001});
      pulse_req(2'b10);
      repeat (100) @(posedge CLK);
      pulse_req(2'b10);
      wait_drain("rereq", 2500);
      repeat (20) @(negedge CLK);
      chk("rereq_idle", 64'(BUSY), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
